iob_div_ctrl: RTL and testbench

Operand-conditioning and result-fixup controller placed directly around the sub-shift unsigned divider. Accepts signed or unsigned dividend/divisor over a valid/ready handshake and converts them to magnitudes. Drives the divider's start/operand pins, waits for its done pulse and restores the result signs. Presents quotient/remainder on a held valid/ready output. Divide-by-zero is resolved locally without starting the divider.

---
 rtl/iob_div_ctrl.sv | 161 ++++++++++++++++
 tb/tb_iob_div_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iob_div_ctrl.sv
// iob_div_ctrl: operand conditioning and result sign fix-up around an unsigned iterative divider.
// Build option IOB_DIV_CTRL_SIGNED_EN enables signed_i; without it every operation is unsigned.
module iob_div_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              rst_n_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o,
   output logic              div_start_o,
   output logic [DATA_W-1:0] div_dividend_o,
   output logic [DATA_W-1:0] div_divisor_o,
   input  logic              div_done_i,
   input  logic [DATA_W-1:0] div_quotient_i,
   input  logic [DATA_W-1:0] div_remainder_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BUSY,
      S_DONE,
      S_ZERO,
      S_OUT
   } state_t;

   state_t            state_q;
   logic              start_q;
   logic              valid_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] dvd_q;
   logic [DATA_W-1:0] dvs_q;
   logic [DATA_W-1:0] raw_dvd_q;

   logic [DATA_W-1:0] dvd_mag_d;
   logic [DATA_W-1:0] dvs_mag_d;
   logic [DATA_W-1:0] quo_fix_d;
   logic [DATA_W-1:0] rem_fix_d;
   logic              accept;
   logic              divisor_zero;

`ifdef IOB_DIV_CTRL_SIGNED_EN
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;

   // Negation is modulo 2^DATA_W, so the most-negative value maps onto itself.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      neg_quo_d = signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
      neg_rem_d = signed_i & dividend_i[DATA_W-1];
      dvd_mag_d = neg_rem_d ? ('0 - dividend_i) : dividend_i;
      dvs_mag_d = (signed_i & divisor_i[DATA_W-1]) ? ('0 - divisor_i) : divisor_i;
      quo_fix_d = neg_quo_q ? ('0 - div_quotient_i)  : div_quotient_i;
      rem_fix_d = neg_rem_q ? ('0 - div_remainder_i) : div_remainder_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (cke_i && accept) begin
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end
`else
   logic unused_signed;

   assign unused_signed = signed_i;
   assign dvd_mag_d     = dividend_i;
   assign dvs_mag_d     = divisor_i;
   assign quo_fix_d     = div_quotient_i;
   assign rem_fix_d     = div_remainder_i;
`endif

   // Ready is gated by cke_i and reset so a handshake is never seen while the FSM cannot move.
   assign in_ready_o   = rst_n_i & cke_i & (state_q == S_IDLE) & div_done_i;
   assign accept       = in_valid_i & in_ready_o;
   assign divisor_zero = (divisor_i == '0);

   // NOTE: sequential state uses non-blocking assignments only; the synchronous reset
   // overrides cke_i so the controller always recovers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         start_q   <= 1'b0;
         valid_q   <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         raw_dvd_q <= '0;
      end else if (cke_i) begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  dvd_q     <= dvd_mag_d;
                  dvs_q     <= dvs_mag_d;
                  raw_dvd_q <= dividend_i;
                  if (divisor_zero) begin
                     state_q <= S_ZERO;
                  end else begin
                     state_q <= S_START;
                     start_q <= 1'b1;
                  end
               end
            end
            S_START: begin
               start_q <= 1'b0;
               state_q <= S_BUSY;
            end
            // The done level seen during START is stale; wait for the divider to drop it.
            S_BUSY: begin
               if (!div_done_i) state_q <= S_DONE;
            end
            S_DONE: begin
               if (div_done_i) begin
                  quo_q   <= quo_fix_d;
                  rem_q   <= rem_fix_d;
                  valid_q <= 1'b1;
                  state_q <= S_OUT;
               end
            end
            S_ZERO: begin
               quo_q   <= '1;
               rem_q   <= raw_dvd_q;
               valid_q <= 1'b1;
               state_q <= S_OUT;
            end
            S_OUT: begin
               if (out_ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               start_q <= 1'b0;
               valid_q <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign out_valid_o    = valid_q;
   assign quotient_o     = quo_q;
   assign remainder_o    = rem_q;
   assign div_start_o    = start_q;
   assign div_dividend_o = dvd_q;
   assign div_divisor_o  = dvs_q;

endmodule

// File: tb/tb_iob_div_ctrl.sv
// Directed bench for iob_div_ctrl with a fixed-latency behavioural model of the unsigned divider.
// Expected values follow the IOB_DIV_CTRL_SIGNED_EN build option of the design.
module tb_iob_div_ctrl;

   logic        clk = 1'b0;
   logic        cke;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        sgn;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_start;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_done = 1'b1;
   logic [31:0] div_quotient = '0;
   logic [31:0] div_remainder = '0;
   int          div_cnt = 0;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   iob_div_ctrl #(.DATA_W(32)) dut (
      .clk_i          (clk),
      .cke_i          (cke),
      .rst_n_i        (rst_n),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .signed_i       (sgn),
      .dividend_i     (dividend),
      .divisor_i      (divisor),
      .out_valid_o    (out_valid),
      .out_ready_i    (out_ready),
      .quotient_o     (quotient),
      .remainder_o    (remainder),
      .div_start_o    (div_start),
      .div_dividend_o (div_dividend),
      .div_divisor_o  (div_divisor),
      .div_done_i     (div_done),
      .div_quotient_i (div_quotient),
      .div_remainder_i(div_remainder)
   );

   always #5 clk = ~clk;

   // Divider model: start accepted while done, then done low for 32 cycles; never reset.
   always @(posedge clk) begin
      if (div_start && div_done) begin
         div_done      <= 1'b0;
         div_cnt       <= 32;
         div_quotient  <= (div_divisor != 0) ? div_dividend / div_divisor : 32'hFFFF_FFFF;
         div_remainder <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
      end else if (div_cnt > 0) begin
         div_cnt <= div_cnt - 1;
         if (div_cnt == 1) div_done <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One operation with out_ready held 1; counts cycles from the accept cycle to out_valid.
   task automatic do_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int elat, input int estarts);
      int cyc;
      int starts;
      int start_cyc;
      @(negedge clk);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      sgn      = s;
      dividend = a;
      divisor  = b;
      cyc       = 0;
      starts    = 0;
      start_cyc = -1;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            in_valid = 1'b0;
            dividend = 32'hDEAD_BEEF;
            divisor  = 32'h0000_0003;
         end
         if (div_start) begin
            starts++;
            if (start_cyc < 0) start_cyc = cyc;
         end
      end while (!out_valid && cyc < 200);
      check({tag, "_latency"}, cyc, elat);
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_remainder"}, remainder, er);
      check({tag, "_starts"}, starts, estarts);
      if (estarts > 0) check({tag, "_start_cycle"}, start_cyc, 1);
      @(negedge clk);
      check({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int cyc;
      int ov_seen;
      cke       = 1'b1;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      sgn       = 1'b0;
      dividend  = '0;
      divisor   = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_div_start", {31'd0, div_start}, 32'd0);
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_div_dividend", div_dividend, 32'd0);
      check("rst_div_divisor", div_divisor, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Unsigned basic
      do_op("u_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 35, 1);

      // Signed operands (plain unsigned results when signed support is not built in)
`ifdef IOB_DIV_CTRL_SIGNED_EN
      do_op("s_m100_7",  1'b1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 35, 1);
      do_op("s_100_m7",  1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         35, 1);
      do_op("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 35, 1);
      do_op("s_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         35, 1);
`else
      do_op("s_m100_7",  1'b1, 32'hFFFF_FF9C, 32'd7,        32'h2492_4916, 32'd2,         35, 1);
      do_op("s_100_m7",  1'b1, 32'd100,       32'hFFFF_FFF9, 32'd0,         32'd100,       35, 1);
      do_op("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FF9C, 35, 1);
      do_op("s_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 35, 1);
`endif
      do_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 35, 1);

      // Divide by zero, both modes
      do_op("u_div0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 2, 0);
      do_op("s_div0", 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 2, 0);

      // Backpressure: hold the result, ignore new operands, clock-enable freeze, then release
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      sgn      = 1'b0;
      dividend = 32'd20;
      divisor  = 32'd6;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) in_valid = 1'b0;
      end while (!out_valid && cyc < 200);
      check("bp_latency", cyc, 35);
      in_valid = 1'b1;
      dividend = 32'd77;
      divisor  = 32'd5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_quotient", quotient, 32'd3);
         check("bp_hold_remainder", remainder, 32'd2);
         check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold_div_dividend", div_dividend, 32'd20);
      end
      in_valid  = 1'b0;
      cke       = 1'b0;
      out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("cke_freeze_valid", {31'd0, out_valid}, 32'd1);
      end
      cke = 1'b1;
      @(negedge clk);
      check("bp_release_valid", {31'd0, out_valid}, 32'd0);
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);

      // Reset while the divider is iterating; the divider model keeps running
      @(negedge clk);
      in_valid = 1'b1;
      sgn      = 1'b0;
      dividend = 32'd1000;
      divisor  = 32'd10;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_wait_ready", {31'd0, in_ready}, 32'd0);
      cyc     = 0;
      ov_seen = 0;
      while (!in_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (out_valid) ov_seen = 1;
      end
      check("mid_rst_wait_cycles", cyc, 26);
      check("mid_rst_no_valid", ov_seen, 0);
      do_op("u_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 35, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
